alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multi-cycle ALU execution unit. It consumes the 3-bit `alu_control` code that the ALU control decoder produces, together with two operands, and returns a registered result and a zero flag. The unit sits in the execute stage between operand fetch and writeback. It uses valid/ready handshakes on both sides. Shifts run iteratively, one bit per cycle, unless the barrel shifter is compiled in.

## Interface
- `XLEN`, 32: operand and result width.
- `SHAMT_W`, `$clog2(XLEN)`: shift-amount width, taken from `op_b[SHAMT_W-1:0]`.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands and control are valid.
- `in_ready` output 1: the unit can accept a new operation this cycle.
- `alu_control` input 3: operation code.
  - 000 ADD, 001 SUB, 010 AND, 011 OR.
  - 100 XOR, 101 SLT (signed), 110 SLL, 111 SRL (logical).
- `op_a` input XLEN: first operand.
- `op_b` input XLEN: second operand, or the shift amount in its low `SHAMT_W` bits.
- `out_valid` output 1: `result` and `zero` are valid.
- `out_ready` input 1: the consumer takes the result.
- `result` output XLEN: registered result.
- `zero` output 1: registered flag, `result == 0`.
- `busy` output 1: state is SHIFT.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Accept condition: `in_valid & in_ready`. `in_ready` = (state == IDLE) | (state == DONE & `out_ready`).
- On accept of a non-shift op, or a shift with amount 0:
  - Compute combinationally and register `result`/`zero`.
  - Next state is DONE.
- On accept of SLL/SRL with amount s ≠ 0:
  - Load `op_a` into the shift register and s into the down-counter.
  - Next state is SHIFT.
- SHIFT:
  - Each cycle, shift by 1 (SLL inserts 0 at the LSB, SRL inserts 0 at the MSB) and decrement the counter.
  - When the counter reaches 1 → DONE, with the final value in `result`.
- DONE:
  - `out_valid` = 1, and `result`/`zero` are held stable until `out_ready`.
  - On `out_ready` without a new accept → IDLE.
  - On `out_ready` with a same-cycle accept → behave as an accept from IDLE.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN; no carry or overflow output.
  - SLT gives `{XLEN-1 zeros, signed(op_a) < signed(op_b)}`.
  - Upper `op_b` bits are ignored for shifts.
- `alu_control` and the operands are sampled only on accept. Changes while the unit is busy have no effect.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `result` 0, `zero` 1 (consistent with `result`), `busy` 0, counter 0.
- Accept in cycle N for a non-shift op → `out_valid` in cycle N+1.
- Shift by s ≥ 1 → `out_valid` in cycle N+1+s; `busy` is high in cycles N+1..N+s.
- Maximum latency is XLEN (shift by XLEN-1).
- Throughput: one operation per cycle for back-to-back non-shift ops when `out_ready` is held high.
- Backpressure: DONE is held indefinitely, with no result change, while `out_ready` = 0.
- Asserting `rst_n` low mid-SHIFT or in DONE aborts the operation immediately (asynchronously). The pending result is discarded and outputs return to reset values.

## Configuration
- `ALU_BARREL_SHIFT_EN`:
  - Defined: SLL/SRL are computed combinationally on accept, latency 1 like every other op. The SHIFT state and counter are not generated, and `busy` is tied to 0.
  - Undefined: iterative shifting exactly as described above.

## Structure
- Shared package `alu_pkg` holds:
  - The 3-bit `alu_control` encoding constants (shared with the ALU control decoder).
  - The FSM state enum.
  - The default `XLEN`.
- Sub-module `alu_shift_iter`:
  - Holds the shift register, down-counter and done pulse.
  - Instantiated only when `ALU_BARREL_SHIFT_EN` is undefined.

## Test plan
- ADD 5 + 7, accepted cycle N → `result` 12, `zero` 0, `out_valid` in N+1.
- SUB 3 − 5 → `result` 0xFFFFFFFE, `zero` 0; SUB 9 − 9 → `result` 0, `zero` 1.
- SLT `op_a` 0xFFFFFFFF, `op_b` 1 → `result` 1; swapped operands → 0.
- SLL 1 by 31:
  - Macro undefined → `result` 0x80000000, `out_valid` in N+32, `busy` high for 31 cycles.
  - Macro defined → same result in N+1.
- SRL 0x80000000 by 0 → `result` 0x80000000 in N+1.
- Hold `out_ready` = 0 for 5 cycles in DONE → `result` stable, `in_ready` 0. Then a new ADD with `out_ready` = 1 is accepted in the same cycle.
- Pull `rst_n` low mid-shift (shift by 20, at cycle N+10) → `out_valid` 0 and `in_ready` 1 immediately, with no stale result after release.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared alu_control encodings, FSM state type and default width for the ALU execute stage.
// Encodings are also consumed by the ALU control decoder, so keep them in sync with it.
package alu_pkg;

  localparam int ALU_XLEN_DEFAULT = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: one-bit-per-cycle logical shifter with down-counter; used when ALU_BARREL_SHIFT_EN is undefined.
// Latency: loads on start, shifts once per active cycle; done pulses alongside the final shift step.
// Backpressure: none; the owning FSM gates progress through start/active.
module alu_shift_iter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               shift_left,
  input  logic [XLEN-1:0]    load_val,
  input  logic [SHAMT_W-1:0] load_amt,
  input  logic               active,
  output logic [XLEN-1:0]    shift_val,
  output logic               done
);

  logic [XLEN-1:0]    sh_reg;
  logic [SHAMT_W-1:0] cnt;
  logic               left_q;

  // shift_val is the value after this cycle's step, so the final step can be captured directly
  assign shift_val = left_q ? (sh_reg << 1) : (sh_reg >> 1);
  assign done      = active && (cnt == SHAMT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg <= '0;
      cnt    <= '0;
      left_q <= 1'b0;
    end else if (start) begin
      sh_reg <= load_val;
      cnt    <= load_amt;
      left_q <= shift_left;
    end else if (active && (cnt != '0)) begin
      sh_reg <= shift_val;
      cnt    <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: valid/ready ALU execute stage; define ALU_BARREL_SHIFT_EN for single-cycle shifts.
// Latency: 1 cycle per op; shift by s != 0 takes 1+s cycles unless the barrel shifter is built.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or in DONE with out_ready.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = ALU_XLEN_DEFAULT,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  alu_state_e         state;
  alu_state_e         state_nxt;
  logic               accept;
  logic               is_shift;
  logic               res_load;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    comb_res;
  logic               shift_start;
  logic               shift_done;
  logic [XLEN-1:0]    shift_val;

  assign shamt     = op_b[SHAMT_W-1:0];
  assign is_shift  = (alu_control == ALU_SLL) || (alu_control == ALU_SRL);
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);

  always_comb begin
    comb_res = '0;
    unique case (alu_control)
      ALU_ADD: comb_res = op_a + op_b;
      ALU_SUB: comb_res = op_a - op_b;
      ALU_AND: comb_res = op_a & op_b;
      ALU_OR:  comb_res = op_a | op_b;
      ALU_XOR: comb_res = op_a ^ op_b;
      ALU_SLT: comb_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SLL: comb_res = op_a << shamt;
      ALU_SRL: comb_res = op_a >> shamt;
`else
      // only reached for a zero shift amount; non-zero amounts go to the iterative shifter
      ALU_SLL: comb_res = op_a;
      ALU_SRL: comb_res = op_a;
`endif
      default: comb_res = '0;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign shift_start = 1'b0;
  assign shift_done  = 1'b0;
  assign shift_val   = '0;
  assign busy        = 1'b0;
`else
  assign shift_start = accept && is_shift && (shamt != '0);
  assign busy        = (state == ST_SHIFT);

  alu_shift_iter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (shift_start),
    .shift_left (alu_control == ALU_SLL),
    .load_val   (op_a),
    .load_amt   (shamt),
    .active     (state == ST_SHIFT),
    .shift_val  (shift_val),
    .done       (shift_done)
  );
`endif

  always_comb begin
    state_nxt = state;
    res_load  = 1'b0;
    case (state)
      ST_SHIFT: begin
        if (shift_done) state_nxt = ST_DONE;
      end
      ST_IDLE, ST_DONE: begin
        // a same-cycle accept in DONE is treated exactly like an accept from IDLE
        if (accept) begin
          if (shift_start) begin
            state_nxt = ST_SHIFT;
          end else begin
            state_nxt = ST_DONE;
            res_load  = 1'b1;
          end
        end else if ((state == ST_DONE) && out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      state <= state_nxt;
      if (res_load) begin
        result <= comb_res;
        zero   <= (comb_res == '0);
      end else if (shift_done) begin
        result <= shift_val;
        zero   <= (shift_val == '0);
      end
    end
  end

  // the is_shift decode only steers the iterative path; keep it referenced for the barrel build
  logic unused_ok;
  assign unused_ok = is_shift;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with hand-computed results for alu_exec_unit.
// Honours ALU_BARREL_SHIFT_EN for expected shift latency and busy behaviour.
module tb_alu_exec_unit;

  localparam int XLEN = 32;
`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      alu_control = 3'b000;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int shift_lat(input int s);
    return (BARREL || s == 0) ? 1 : s + 1;
  endfunction

  // Accept one op, wait for out_valid with garbage inputs held valid, then drain it.
  task automatic run_op(input string tag, input logic [2:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    int nbusy;
    int exp_busy;
    exp_busy = exp_lat - 1;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; alu_control = ctrl; op_a = a; op_b = b; out_ready = 1'b0;
    @(negedge clk);
    alu_control = ~ctrl; op_a = ~a; op_b = 32'h0000_0003;
    cyc = 1;
    nbusy = 0;
    while (!out_valid && cyc <= XLEN + 4) begin
      nbusy += int'(busy);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, ".result"}, result, exp_res);
    check({tag, ".zero"}, 32'(zero), 32'(exp_res == 32'd0));
    check({tag, ".busy_cycles"}, 32'(nbusy), 32'(exp_busy));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int seen_valid;

    #12;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.zero", 32'(zero), 32'd1);
    check("rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add",     3'b000, 32'd5,         32'd7,         32'd12,        1);
    run_op("sub_neg", 3'b001, 32'd3,         32'd5,         32'hFFFF_FFFE, 1);
    run_op("sub_eq",  3'b001, 32'd9,         32'd9,         32'd0,         1);
    run_op("and",     3'b010, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1);
    run_op("or",      3'b011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1);
    run_op("xor",     3'b100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
    run_op("add_wrap",3'b000, 32'hFFFF_FFFF, 32'd1,         32'd0,         1);
    run_op("slt_t",   3'b101, 32'hFFFF_FFFF, 32'd1,         32'd1,         1);
    run_op("slt_f",   3'b101, 32'd1,         32'hFFFF_FFFF, 32'd0,         1);
    run_op("sll31",   3'b110, 32'd1,         32'd31,        32'h8000_0000, shift_lat(31));
    run_op("srl0",    3'b111, 32'h8000_0000, 32'd0,         32'h8000_0000, shift_lat(0));
    run_op("srl4_hi", 3'b111, 32'h8000_0000, 32'hFFFF_FFE4, 32'h0800_0000, shift_lat(4));
    run_op("sll1",    3'b110, 32'd3,         32'd1,         32'd6,         shift_lat(1));
    run_op("srl_out", 3'b111, 32'h0000_0001, 32'd1,         32'd0,         shift_lat(1));

    // backpressure in DONE, then same-cycle drain + accept and back-to-back throughput
    @(negedge clk);
    in_valid = 1'b1; alu_control = 3'b000; op_a = 32'd10; op_b = 32'd20; out_ready = 1'b0;
    @(negedge clk);
    alu_control = 3'b001; op_a = 32'd99; op_b = 32'd1;
    check("bp.valid", 32'(out_valid), 32'd1);
    check("bp.result0", result, 32'd30);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp.hold%0d.result", i), result, 32'd30);
      check($sformatf("bp.hold%0d.in_ready", i), 32'(in_ready), 32'd0);
    end
    alu_control = 3'b000; op_a = 32'd1; op_b = 32'd1; out_ready = 1'b1;
    #1;
    check("bp.in_ready_on_drain", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("b2b.valid1", 32'(out_valid), 32'd1);
    check("b2b.result1", result, 32'd2);
    op_a = 32'd3; op_b = 32'd4;
    @(negedge clk);
    check("b2b.valid2", 32'(out_valid), 32'd1);
    check("b2b.result2", result, 32'd7);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b.drained", 32'(out_valid), 32'd0);

    // asynchronous reset in the middle of a shift by 20
    @(negedge clk);
    in_valid = 1'b1; alu_control = 3'b110; op_a = 32'd1; op_b = 32'd20; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("arst.busy_before", 32'(busy), BARREL ? 32'd0 : 32'd1);
    check("arst.valid_before", 32'(out_valid), BARREL ? 32'd1 : 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.in_ready", 32'(in_ready), 32'd1);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.result", result, 32'd0);
    check("arst.zero", 32'(zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    repeat (25) begin
      @(negedge clk);
      seen_valid += int'(out_valid);
    end
    check("arst.no_stale_valid", 32'(seen_valid), 32'd0);
    check("arst.result_after", result, 32'd0);

    run_op("post_rst_add", 3'b000, 32'd100, 32'd23, 32'd123, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
